jericalla_issue_ctrl: RTL and testbench

// Instruction issue controller in front of the JericallaEvo datapath (regfile -> pipe reg 1 -> ALU -> pipe reg 2 -> writeback/memory).

---
 rtl/jericalla_pkg.sv | 35 +++
 rtl/jericalla_instr_fifo.sv | 64 ++++++
 rtl/jericalla_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_jericalla_issue_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla issue controller.
// Holds the opcode encodings, instruction field positions, the issue FSM state type and
// the decode helper that tells whether an opcode writes a destination register.
package jericalla_pkg;

   localparam int unsigned INSTR_W = 17;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_TERN = 2'b10;
   localparam logic [1:0] OP_SW   = 2'b11;

   // Instruction layout: {op[16:15], rd[14:10], rs1[9:5], rs2[4:0]}
   localparam int unsigned OP_MSB  = 16;
   localparam int unsigned OP_LSB  = 15;
   localparam int unsigned RD_MSB  = 14;
   localparam int unsigned RD_LSB  = 10;
   localparam int unsigned RS1_MSB = 9;
   localparam int unsigned RS1_LSB = 5;
   localparam int unsigned RS2_MSB = 4;
   localparam int unsigned RS2_LSB = 0;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StStall,
      StDrain
   } issue_state_t;

   // Every opcode except the store writes rd.
   function automatic logic writes_reg(input logic [1:0] op);
      return op != OP_SW;
   endfunction

endpackage

// File: rtl/jericalla_instr_fifo.sv
// Synchronous instruction FIFO with occupancy count.
// Ports: clock/reset (sync, active-high), push/wdata write side, pop/rdata read side
// (rdata shows the head entry combinationally), count = current occupancy.
// Push is ignored when full and pop is ignored when empty; simultaneous push and pop
// both take effect and leave the count unchanged.
module jericalla_instr_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 17
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q != FullCnt);
      do_pop   = pop && (count_q != '0);
      // Depth is a power of two, so the pointers wrap by natural overflow.
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/jericalla_issue_ctrl.sv
// Instruction issue controller for the JericallaEvo datapath.
// Ports: clock/reset (sync, active-high); in_instr/in_valid/in_ready host push interface;
// run enables issuing; instruction/issue_valid/stall are registered issue outputs;
// busy is high whenever the FSM is not idle; fifo_count is FIFO occupancy;
// issued_count/stall_count are wrapping statistics counters.
// A PIPE_DEPTH-entry shift scoreboard tracks in-flight destination registers; the FIFO
// head is held back (bubble with stall=1) while it reads any of them.
module jericalla_issue_ctrl
   import jericalla_pkg::*;
#(
   parameter int unsigned        FIFO_DEPTH   = 8,
   parameter int unsigned        PIPE_DEPTH   = 2,
   parameter logic [INSTR_W-1:0] BUBBLE_INSTR = 17'h0,
   parameter int unsigned        CNT_W        = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [INSTR_W-1:0]            in_instr,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          run,
   output logic [INSTR_W-1:0]            instruction,
   output logic                          issue_valid,
   output logic                          stall,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]              issued_count,
   output logic [CNT_W-1:0]              stall_count
);

   localparam int unsigned FCntW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [FCntW-1:0] FifoFull = FCntW'(FIFO_DEPTH);

   issue_state_t         state_q, state_d;
   logic [INSTR_W-1:0]   head;
   logic                 fifo_push, fifo_empty;
   logic                 hazard, active, do_issue, do_stall;
   logic [PIPE_DEPTH-1:0] sb_v_q, sb_v_d;
   logic [4:0]           sb_rd_q [PIPE_DEPTH];
   logic [4:0]           sb_rd_d [PIPE_DEPTH];
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 valid_q, valid_d;
   logic                 stall_q, stall_d;
   logic [CNT_W-1:0]     issued_q, issued_d;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

   assign in_ready   = fifo_count != FifoFull;
   assign fifo_push  = in_valid && in_ready;
   assign fifo_empty = fifo_count == '0;

   jericalla_instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (do_issue),
      .wdata (in_instr),
      .rdata (head),
      .count (fifo_count)
   );

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         if (sb_v_q[i] && ((sb_rd_q[i] == head[RS1_MSB:RS1_LSB]) ||
                           (sb_rd_q[i] == head[RS2_MSB:RS2_LSB]))) begin
            hazard = 1'b1;
         end
      end
   end

   // Issue decisions are only made while running in ISSUE/STALL with a real head entry.
   always_comb begin
      active   = ((state_q == StIssue) || (state_q == StStall)) && run;
      do_issue = active && !fifo_empty && !hazard;
      do_stall = active && !fifo_empty && hazard;
   end

   always_comb begin
      sb_v_d     = '0;
      sb_v_d[0]  = do_issue && writes_reg(head[OP_MSB:OP_LSB]);
      sb_rd_d[0] = head[RD_MSB:RD_LSB];
      for (int i = 1; i < PIPE_DEPTH; i++) begin
         sb_v_d[i]  = sb_v_q[i-1];
         sb_rd_d[i] = sb_rd_q[i-1];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (run && !fifo_empty) state_d = StIssue;
         end
         StIssue, StStall: begin
            if (!run)          state_d = StDrain;
            else if (do_stall) state_d = StStall;
            else               state_d = StIssue;
         end
         StDrain: begin
            if (run)                 state_d = StIssue;
            else if (sb_v_q == '0)   state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      instr_d     = do_issue ? head : BUBBLE_INSTR;
      valid_d     = do_issue;
      stall_d     = do_stall;
      issued_d    = issued_q + CNT_W'(do_issue);
      stall_cnt_d = stall_cnt_q + CNT_W'(do_stall);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         sb_v_q      <= '0;
         instr_q     <= BUBBLE_INSTR;
         valid_q     <= 1'b0;
         stall_q     <= 1'b0;
         issued_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sb_v_q      <= sb_v_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         stall_q     <= stall_d;
         issued_q    <= issued_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Register tags are don't-care while their valid bit is clear.
   always_ff @(posedge clock) begin
      sb_rd_q <= sb_rd_d;
   end

   assign instruction  = instr_q;
   assign issue_valid  = valid_q;
   assign stall        = stall_q;
   assign busy         = state_q != StIdle;
   assign issued_count = issued_q;
   assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_jericalla_issue_ctrl.sv
// Directed bench for jericalla_issue_ctrl. Accepted instructions are queued as expected
// issues; a monitor pops and compares every issue_valid cycle.
module tb_jericalla_issue_ctrl;

   logic        clock;
   logic        reset;
   logic [16:0] in_instr;
   logic        in_valid;
   logic        in_ready;
   logic        run;
   logic [16:0] instruction;
   logic        issue_valid;
   logic        stall;
   logic        busy;
   logic [3:0]  fifo_count;
   logic [15:0] issued_count;
   logic [15:0] stall_count;

   int compared = 0;
   int mismatched = 0;
   logic [16:0] exp_q [$];

   jericalla_issue_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .in_instr     (in_instr),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .run          (run),
      .instruction  (instruction),
      .issue_valid  (issue_valid),
      .stall        (stall),
      .busy         (busy),
      .fifo_count   (fifo_count),
      .issued_count (issued_count),
      .stall_count  (stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [16:0] mk(input logic [1:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, rd, rs1, rs2};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   // Main steps sample at +2 so the monitor (+1) has already consumed the edge.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic drive_push(input logic [16:0] ins);
      in_valid = 1'b1;
      in_instr = ins;
      exp_q.push_back(ins);
   endtask

   always @(posedge clock) begin
      #1;
      if (issue_valid === 1'b1) begin
         compared++;
         assert (exp_q.size() != 0) else begin
            mismatched++;
            $error("FAIL issue_unexpected: observed=%0h required=no issue", instruction);
         end
         if (exp_q.size() != 0) begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("issue_instr", {15'd0, instruction}, {15'd0, e});
         end
      end
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b1;
      in_instr = 17'h1abcd;
      run      = 1'b0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_issue_valid", issue_valid, 0);
      check("rst_instruction", instruction, 0);
      check("rst_stall", stall, 0);
      check("rst_busy", busy, 0);
      check("rst_issued_count", issued_count, 0);
      check("rst_stall_count", stall_count, 0);
      reset    = 1'b0;
      in_valid = 1'b0;

      // Independent stream: three consecutive issues.
      run = 1'b1;
      drive_push(mk(2'b00, 5'd4, 5'd0, 5'd1));
      tick();
      drive_push(mk(2'b01, 5'd5, 5'd1, 5'd2));
      tick();
      drive_push(mk(2'b11, 5'd0, 5'd7, 5'd3));
      tick();
      check("ind_valid0", issue_valid, 1);
      in_valid = 1'b0;
      tick();
      check("ind_valid1", issue_valid, 1);
      check("ind_stall1", stall, 0);
      tick();
      check("ind_valid2", issue_valid, 1);
      tick();
      check("ind_bubble", issue_valid, 0);
      check("ind_bubble_stall", stall, 0);
      check("ind_issued", issued_count, 3);
      check("ind_stalls", stall_count, 0);

      // RAW on r4: two hazard bubbles, then issue.
      drive_push(mk(2'b00, 5'd4, 5'd0, 5'd1));
      tick();
      drive_push(mk(2'b01, 5'd5, 5'd4, 5'd2));
      tick();
      check("raw_first", issue_valid, 1);
      in_valid = 1'b0;
      tick();
      check("raw_b1_valid", issue_valid, 0);
      check("raw_b1_stall", stall, 1);
      check("raw_b1_instr", instruction, 0);
      tick();
      check("raw_b2_valid", issue_valid, 0);
      check("raw_b2_stall", stall, 1);
      tick();
      check("raw_issue", issue_valid, 1);
      check("raw_issue_stall", stall, 0);
      check("raw_stalls", stall_count, 2);
      check("raw_issued", issued_count, 5);

      // A store writes nothing, so a reader of r7/r4 follows immediately.
      drive_push(mk(2'b11, 5'd0, 5'd7, 5'd4));
      tick();
      drive_push(mk(2'b00, 5'd8, 5'd7, 5'd4));
      tick();
      check("sw_first", issue_valid, 1);
      in_valid = 1'b0;
      tick();
      check("sw_second", issue_valid, 1);
      check("sw_no_stall", stall, 0);
      check("sw_stalls", stall_count, 2);
      check("sw_issued", issued_count, 7);

      // Fill the FIFO with run low.
      run = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive_push(mk(2'b00, 5'(16 + i), 5'd1, 5'd2));
         tick();
      end
      check("full_count", fifo_count, 8);
      check("full_ready", in_ready, 0);
      in_instr = mk(2'b10, 5'd31, 5'd31, 5'd31);
      tick();
      check("full_reject", fifo_count, 8);
      run = 1'b1;
      in_instr = mk(2'b00, 5'd24, 5'd1, 5'd2);
      tick();
      check("full_wake_count", fifo_count, 8);
      check("full_wake_valid", issue_valid, 0);
      tick();
      check("full_pop_count", fifo_count, 7);
      check("full_pop_ready", in_ready, 1);
      check("full_pop_valid", issue_valid, 1);
      exp_q.push_back(in_instr);
      tick();
      check("full_pp_count0", fifo_count, 7);
      drive_push(mk(2'b00, 5'd25, 5'd1, 5'd2));
      tick();
      check("full_pp_count1", fifo_count, 7);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         tick();
      end
      check("full_drained", exp_q.size(), 0);
      check("full_issued", issued_count, 17);
      check("full_empty", fifo_count, 0);

      // Drop run during a RAW stall.
      drive_push(mk(2'b00, 5'd3, 5'd1, 5'd2));
      tick();
      drive_push(mk(2'b01, 5'd6, 5'd3, 5'd3));
      tick();
      check("drn_first", issue_valid, 1);
      in_valid = 1'b0;
      tick();
      check("drn_stall", stall, 1);
      run = 1'b0;
      tick();
      check("drn_busy", busy, 1);
      check("drn_stall_low", stall, 0);
      check("drn_valid", issue_valid, 0);
      tick();
      check("drn_idle", busy, 0);
      check("drn_count", fifo_count, 1);
      check("drn_stalls", stall_count, 3);

      // Reset while issuing flushes everything.
      run = 1'b1;
      drive_push(mk(2'b00, 5'd9, 5'd1, 5'd2));
      tick();
      in_valid = 1'b0;
      tick();
      check("mid_valid", issue_valid, 1);
      check("mid_busy", busy, 1);
      check("mid_count", fifo_count, 1);
      reset = 1'b1;
      tick();
      exp_q.delete();
      check("mr_valid", issue_valid, 0);
      check("mr_instr", instruction, 0);
      check("mr_stall", stall, 0);
      check("mr_busy", busy, 0);
      check("mr_count", fifo_count, 0);
      check("mr_ready", in_ready, 1);
      check("mr_issued", issued_count, 0);
      check("mr_stalls", stall_count, 0);
      reset = 1'b0;
      tick();
      tick();
      check("post_count", fifo_count, 0);
      check("post_valid", issue_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
